// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 set-2 keyboard path: decoder states,
// scan code constants and the ASCII control characters it emits.
package ps2_kbd_pkg;

    // Decoder position within a make / break / extended prefix sequence
    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } kbd_state_e;

    // Prefix and modifier scan codes
    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] LSHIFT    = 8'h12;
    localparam logic [7:0] RSHIFT    = 8'h59;
    localparam logic [7:0] CTRL      = 8'h14;
    localparam logic [7:0] CAPS      = 8'h58;
    localparam logic [7:0] ACK       = 8'hFA;
    localparam logic [7:0] BAT       = 8'hAA;
    // Enter; after the extended prefix it is the keypad Enter key
    localparam logic [7:0] KEY_ENTER = 8'h5A;

    // ASCII control characters
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] TAB = 8'h09;
    localparam logic [7:0] ESC = 8'h1B;

endpackage

// File: rtl/ps2_char_fifo_if.sv
// Byte stream in from the PS/2 receiver and valid/ready character stream out.
interface ps2_char_fifo_if;
    logic [7:0] code_in;
    logic       code_valid;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;

    // Receiver and consumer side (drives codes, accepts characters)
    modport master (
        output code_in, code_valid, char_ready,
        input  char_out, char_valid
    );

    // Character buffer side
    modport slave (
        input  code_in, code_valid, char_ready,
        output char_out, char_valid
    );
endinterface

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 scan code to ASCII translation under the current
// Shift / Caps / Ctrl state. hit=0 means the key produces no character.
module ps2_ascii_lut
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    input  logic       ctrl,
    output logic [7:0] ascii,
    output logic       hit
);

    logic [4:0]  w_letter;  // 1..26 for a..z, 0 when not a letter
    logic [15:0] w_glyph;   // {plain, shifted}, 0 when unmapped

    // Letter keys map to their alphabet index
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_letter = 5'd0;
        case (code)
            8'h1C: w_letter = 5'd1;   8'h32: w_letter = 5'd2;
            8'h21: w_letter = 5'd3;   8'h23: w_letter = 5'd4;
            8'h24: w_letter = 5'd5;   8'h2B: w_letter = 5'd6;
            8'h34: w_letter = 5'd7;   8'h33: w_letter = 5'd8;
            8'h43: w_letter = 5'd9;   8'h3B: w_letter = 5'd10;
            8'h42: w_letter = 5'd11;  8'h4B: w_letter = 5'd12;
            8'h3A: w_letter = 5'd13;  8'h31: w_letter = 5'd14;
            8'h44: w_letter = 5'd15;  8'h4D: w_letter = 5'd16;
            8'h15: w_letter = 5'd17;  8'h2D: w_letter = 5'd18;
            8'h1B: w_letter = 5'd19;  8'h2C: w_letter = 5'd20;
            8'h3C: w_letter = 5'd21;  8'h2A: w_letter = 5'd22;
            8'h1D: w_letter = 5'd23;  8'h22: w_letter = 5'd24;
            8'h35: w_letter = 5'd25;  8'h1A: w_letter = 5'd26;
            default: w_letter = 5'd0;
        endcase
    end

    // Digits, punctuation and control keys as {plain, shifted} glyph pairs
    always_comb begin
        w_glyph = 16'h0000;
        case (code)
            8'h16: w_glyph = 16'h3121;  // 1 !
            8'h1E: w_glyph = 16'h3240;  // 2 @
            8'h26: w_glyph = 16'h3323;  // 3 #
            8'h25: w_glyph = 16'h3424;  // 4 $
            8'h2E: w_glyph = 16'h3525;  // 5 %
            8'h36: w_glyph = 16'h365E;  // 6 ^
            8'h3D: w_glyph = 16'h3726;  // 7 &
            8'h3E: w_glyph = 16'h382A;  // 8 *
            8'h46: w_glyph = 16'h3928;  // 9 (
            8'h45: w_glyph = 16'h3029;  // 0 )
            8'h0E: w_glyph = 16'h607E;  // ` ~
            8'h4E: w_glyph = 16'h2D5F;  // - _
            8'h55: w_glyph = 16'h3D2B;  // = +
            8'h54: w_glyph = 16'h5B7B;  // [ {
            8'h5B: w_glyph = 16'h5D7D;  // ] }
            8'h5D: w_glyph = 16'h5C7C;  // \ |
            8'h4C: w_glyph = 16'h3B3A;  // ; :
            8'h52: w_glyph = 16'h2722;  // ' "
            8'h41: w_glyph = 16'h2C3C;  // , <
            8'h49: w_glyph = 16'h2E3E;  // . >
            8'h4A: w_glyph = 16'h2F3F;  // / ?
            8'h29: w_glyph = {8'h20, 8'h20};
            8'h5A: w_glyph = {CR, CR};
            8'h66: w_glyph = {BS, BS};
            8'h0D: w_glyph = {TAB, TAB};
            8'h76: w_glyph = {ESC, ESC};
            default: w_glyph = 16'h0000;
        endcase
    end

    // Apply modifiers: Ctrl folds letters to control codes and blocks the rest
    always_comb begin
        ascii = 8'h00;
        hit   = 1'b0;
        if (w_letter != 5'd0) begin
            hit = 1'b1;
            if (ctrl)
                ascii = {3'b000, w_letter};
            else if (shift ^ caps)
                ascii = 8'h40 + {3'b000, w_letter};
            else
                ascii = 8'h60 + {3'b000, w_letter};
        end else if ((w_glyph != 16'h0000) && !ctrl) begin
            hit   = 1'b1;
            ascii = shift ? w_glyph[7:0] : w_glyph[15:8];
        end
    end

endmodule

// File: rtl/ps2_char_fifo.sv
// PS/2 scan code decoder feeding a character FIFO with a valid/ready output.
// Tracks Shift/Ctrl/Caps and keeps sticky overflow and protocol error flags.
module ps2_char_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int CAPS_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    ps2_char_fifo_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic              proto_err,
    input  logic              clr_err,
    output logic [2:0]        mod_state
);

    localparam int              DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_FULL = {1'b1, {ADDR_W{1'b0}}};

    kbd_state_e        r_state;
    logic              r_shift;
    logic              r_ctrl;
    logic              r_caps;
    logic              r_caps_held;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_proto_err;

    logic [7:0]        w_lut_ascii;
    logic              w_lut_hit;
    logic              w_push;
    logic [7:0]        w_push_data;
    logic              w_err;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;

    ps2_ascii_lut u_lut (
        .code  (bus.code_in),
        .shift (r_shift),
        .caps  (r_caps),
        .ctrl  (r_ctrl),
        .ascii (w_lut_ascii),
        .hit   (w_lut_hit)
    );

    // Classify the incoming byte: character to queue, protocol error, or neither
    always_comb begin
        w_push      = 1'b0;
        w_push_data = 8'h00;
        w_err       = 1'b0;
        if (bus.code_valid) begin
            case (r_state)
                IDLE: begin
                    w_push      = w_lut_hit;
                    w_push_data = w_lut_ascii;
                end
                BREAK:     w_err = (bus.code_in == KEY_BREAK) || (bus.code_in == KEY_EXT);
                EXT: begin
                    w_push      = (bus.code_in == KEY_ENTER);
                    w_push_data = CR;
                    w_err       = (bus.code_in == KEY_EXT);
                end
                EXT_BREAK: w_err = (bus.code_in == KEY_BREAK) || (bus.code_in == KEY_EXT);
                default: ;
            endcase
        end
    end

    assign w_full  = (r_count == C_FULL);
    assign w_pop   = (r_count != '0) && bus.char_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // Decoder FSM and modifier state, advanced once per qualified code byte
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= 1'b0;
            r_ctrl      <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (bus.code_valid) begin
            case (r_state)
                IDLE: begin
                    case (bus.code_in)
                        KEY_BREAK:      r_state <= BREAK;
                        KEY_EXT:        r_state <= EXT;
                        LSHIFT, RSHIFT: r_shift <= 1'b1;
                        CTRL:           r_ctrl  <= 1'b1;
                        CAPS: begin
                            // Typematic repeats of a held Caps key must not re-toggle
                            if (CAPS_EN != 0) begin
                                if (!r_caps_held)
                                    r_caps <= ~r_caps;
                                r_caps_held <= 1'b1;
                            end
                        end
                        ACK, BAT: ;
                        default: ;
                    endcase
                end
                BREAK: begin
                    r_state <= IDLE;
                    case (bus.code_in)
                        LSHIFT, RSHIFT: r_shift     <= 1'b0;
                        CTRL:           r_ctrl      <= 1'b0;
                        CAPS:           r_caps_held <= 1'b0;
                        default: ;
                    endcase
                end
                EXT: begin
                    case (bus.code_in)
                        KEY_BREAK: r_state <= EXT_BREAK;
                        CTRL: begin
                            r_ctrl  <= 1'b1;
                            r_state <= IDLE;
                        end
                        default:   r_state <= IDLE;
                    endcase
                end
                EXT_BREAK: begin
                    if (bus.code_in == CTRL)
                        r_ctrl <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Character storage
    // NOTE: the storage array is deliberately left out of reset; validity comes from r_count.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: ;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_err)
                r_overflow <= 1'b0;
            if (w_err)
                r_proto_err <= 1'b1;
            else if (clr_err)
                r_proto_err <= 1'b0;
        end
    end

    assign bus.char_valid = (r_count != '0);
    assign bus.char_out   = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign count          = r_count;
    assign full           = w_full;
    assign overflow       = r_overflow;
    assign proto_err      = r_proto_err;
    assign mod_state      = {r_caps, r_ctrl, r_shift};

endmodule
